// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: shared arbiter state encodings and requester identifiers
package data_mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN_CPU = 2'd1, OWN_EXT = 2'd2} arb_state_t;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_EXT = 1'b1;
endpackage

// File: rtl/data_mem_arbiter_burst_counter.sv
// arb_burst_counter: saturating count of accesses by the current owner, flags when the burst limit is reached
module arb_burst_counter #(
  parameter int MAX_BURST = 4,
  localparam int W = $clog2(MAX_BURST) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic limit
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (reset || clr) ? '0 : (inc && cnt != '1) ? cnt + 1'b1 : cnt;
  assign limit = cnt >= W'(MAX_BURST - 1);
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: bounded-burst round-robin sharing of the data RAM between CPU and external master
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  misalign_err
);
  arb_state_t state, next_state;
  logic last_owner, limit, own_req, oth_req, any_gnt, g_we, aligned, leave;
  arb_burst_counter #(.MAX_BURST(MAX_BURST)) u_cnt (
    .clk(clk), .reset(reset), .clr(leave), .inc(any_gnt), .limit(limit)
  );
  always_comb begin
    cpu_gnt = ~reset & (state == OWN_CPU) & cpu_req;
    ext_gnt = ~reset & (state == OWN_EXT) & ext_req;
    any_gnt = cpu_gnt | ext_gnt;
    g_we = ext_gnt ? ext_we : cpu_gnt & cpu_we;
    mem_addr = ext_gnt ? ext_addr : cpu_gnt ? cpu_addr : '0;
    mem_wdata = ext_gnt ? ext_wdata : cpu_gnt ? cpu_wdata : '0;
    aligned = mem_addr[1:0] == 2'b00;
    mem_we = any_gnt & g_we & aligned;
    mem_re = any_gnt & ~g_we & aligned;
    own_req = (state == OWN_EXT) ? ext_req : cpu_req;
    oth_req = (state == OWN_EXT) ? cpu_req : ext_req;
    next_state = state;
    if (state == IDLE)
      next_state = (cpu_req & ext_req) ? ((last_owner == REQ_EXT) ? OWN_CPU : OWN_EXT)
                 : cpu_req ? OWN_CPU : ext_req ? OWN_EXT : IDLE;
    else if (~own_req | (oth_req & limit))
      next_state = oth_req ? ((state == OWN_CPU) ? OWN_EXT : OWN_CPU) : IDLE;
    leave = (state != IDLE) & (next_state != state);
  end
  assign cpu_stall = cpu_req & ~cpu_gnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_owner <= REQ_EXT;
      cpu_rvalid <= 1'b0;
      ext_rvalid <= 1'b0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
      misalign_err <= 1'b0;
    end else begin
      state <= next_state;
      if (leave) last_owner <= (state == OWN_EXT) ? REQ_EXT : REQ_CPU;
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      ext_rvalid <= ext_gnt & ~ext_we;
      if (cpu_gnt & ~cpu_we) cpu_rdata <= aligned ? mem_rdata : '0;
      if (ext_gnt & ~ext_we) ext_rdata <= aligned ? mem_rdata : '0;
      misalign_err <= any_gnt & ~aligned;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and randomized checks of data_mem_arbiter against a behavioural model
module tb_data_mem_arbiter;
  localparam int MB = 4;
  logic clk = 0, reset = 1;
  logic cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, ext_addr = 0, ext_wdata = 0;
  logic cpu_gnt, cpu_rvalid, cpu_stall, ext_gnt, ext_rvalid, mem_we, mem_re, misalign_err;
  logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram [64];
  logic [31:0] mram [64];
  bit ram_ready = 0, m_init = 0, chk_on = 0;
  int total = 0, bad = 0;
  int own = 0, last = 2, cnt = 0;
  logic m_crv = 0, m_erv = 0, m_err = 0;
  logic [31:0] m_crd = 0, m_erd = 0;
  logic pc, pe;

  data_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed(int i);
    return i == 4 ? 32'hDEADBEEF : 32'(i) * 32'h9E3779B9 + 32'h1234;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [5:0] w;
    logic [1:0] b;
    w = 6'($urandom_range(0, 63));
    b = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return {24'd0, w, b};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic look;
    @(negedge clk);
  endtask

  assign mem_rdata = ram[mem_addr[7:2]];

  always @(posedge clk)
    if (!ram_ready) begin
      for (int i = 0; i < 64; i++) ram[i] <= seed(i);
      ram_ready <= 1;
    end else if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;

  always @(negedge clk) begin
    logic cg, eg, we, al, acc, mine, theirs;
    logic [31:0] a, d;
    if (!m_init) begin
      for (int i = 0; i < 64; i++) mram[i] = seed(i);
      m_init = 1;
    end
    cg = !reset && own == 1 && cpu_req;
    eg = !reset && own == 2 && ext_req;
    acc = cg || eg;
    a = cg ? cpu_addr : eg ? ext_addr : 32'd0;
    d = cg ? cpu_wdata : eg ? ext_wdata : 32'd0;
    we = cg ? cpu_we : eg && ext_we;
    al = a[1:0] == 2'b00;
    if (chk_on) begin
      chk("cpu_gnt", cpu_gnt, cg);
      chk("ext_gnt", ext_gnt, eg);
      chk("cpu_stall", cpu_stall, cpu_req && !cg);
      chk("mem_addr", mem_addr, a);
      chk("mem_wdata", mem_wdata, d);
      chk("mem_we", mem_we, acc && we && al);
      chk("mem_re", mem_re, acc && !we && al);
      chk("cpu_rvalid", cpu_rvalid, m_crv);
      chk("cpu_rdata", cpu_rdata, m_crd);
      chk("ext_rvalid", ext_rvalid, m_erv);
      chk("ext_rdata", ext_rdata, m_erd);
      chk("misalign_err", misalign_err, m_err);
    end
    if (reset) begin
      own = 0; last = 2; cnt = 0;
      m_crv = 0; m_erv = 0; m_crd = 0; m_erd = 0; m_err = 0;
    end else begin
      m_crv = cg && !we;
      m_erv = eg && !we;
      if (m_crv) m_crd = al ? mram[a[7:2]] : 32'd0;
      if (m_erv) m_erd = al ? mram[a[7:2]] : 32'd0;
      m_err = acc && !al;
      if (acc && we && al) mram[a[7:2]] = d;
      if (own == 0) own = (cpu_req && ext_req) ? (last == 2 ? 1 : 2) : cpu_req ? 1 : ext_req ? 2 : 0;
      else begin
        mine = own == 1 ? cpu_req : ext_req;
        theirs = own == 1 ? ext_req : cpu_req;
        if (mine) cnt++;
        if (!mine || (theirs && cnt >= MB)) begin
          last = own;
          cnt = 0;
          own = theirs ? 3 - own : 0;
        end
      end
    end
  end

  initial begin
    reset = 1;
    step;
    chk_on = 1;
    step;
    reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    look; chk("t1 stall", cpu_stall, 1); chk("t1 no gnt", cpu_gnt, 0);
    step; look; chk("t1 gnt", cpu_gnt, 1); chk("t1 re", mem_re, 1); chk("t1 addr", mem_addr, 32'h10);
    step; cpu_req = 0;
    look; chk("t1 rvalid", cpu_rvalid, 1); chk("t1 rdata", cpu_rdata, 32'hDEADBEEF);
    step;
    ext_req = 1; ext_we = 1; ext_addr = 32'h20; ext_wdata = 32'h12345678;
    step; look; chk("t3 ext gnt", ext_gnt, 1); chk("t3 we", mem_we, 1); chk("t3 wdata", mem_wdata, 32'h12345678);
    step; ext_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    look; chk("t3 we once", mem_we, 0); chk("t3 ext released", ext_gnt, 0);
    step; look; chk("t3 cpu gnt", cpu_gnt, 1);
    step; cpu_req = 0;
    look; chk("t3 rvalid", cpu_rvalid, 1); chk("t3 rdata", cpu_rdata, 32'h12345678);
    step;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h22; cpu_wdata = 32'hAAAAAAAA;
    step; look; chk("t4 gnt", cpu_gnt, 1); chk("t4 we", mem_we, 0);
    step; cpu_req = 0;
    look; chk("t4 err", misalign_err, 1); chk("t4 ram", ram[8], 32'h12345678);
    step; look; chk("t4 err pulse", misalign_err, 0); chk("t4 ram kept", ram[8], 32'h12345678);
    step; reset = 1;
    step; reset = 0;
    cpu_req = 1; ext_req = 1; cpu_we = 0; ext_we = 0; cpu_addr = 32'h0; ext_addr = 32'h4;
    look; chk("t2 idle cpu", cpu_gnt, 0); chk("t2 idle ext", ext_gnt, 0);
    step;
    for (int i = 0; i < MB; i++) begin
      look; chk("t2 cpu burst", cpu_gnt, 1); chk("t2 ext wait", ext_gnt, 0);
      step;
    end
    look; chk("t2 ext gnt", ext_gnt, 1); chk("t2 cpu off", cpu_gnt, 0);
    step; look; chk("t5 ext gnt1", ext_gnt, 1);
    step; reset = 1;
    look; chk("t5 abort gnt", ext_gnt, 0); chk("t5 abort re", mem_re, 0);
    step; reset = 0;
    look; chk("t5 idle cpu", cpu_gnt, 0); chk("t5 idle ext", ext_gnt, 0);
    chk("t5 crv", cpu_rvalid, 0); chk("t5 erv", ext_rvalid, 0);
    step; look; chk("t5 cpu first", cpu_gnt, 1);
    step; cpu_req = 0;
    look; chk("t6 drop cpu", cpu_gnt, 0); chk("t6 drop ext", ext_gnt, 0);
    step; look; chk("t6 handover", ext_gnt, 1);
    step; ext_req = 0; cpu_req = 1;
    look; chk("t6 ext drop", cpu_gnt, 0);
    step;
    for (int i = 0; i < 10; i++) begin
      look; chk("t6 long stream", cpu_gnt, 1);
      step;
    end
    ext_req = 1;
    look; chk("t6 last cpu", cpu_gnt, 1);
    step; look; chk("t6 ext after long", ext_gnt, 1); chk("t6 cpu yields", cpu_gnt, 0);
    step; cpu_req = 0; ext_req = 0;
    step;
    repeat (3000) begin
      look; pc = cpu_gnt; pe = ext_gnt;
      step;
      reset = $urandom_range(0, 299) == 0;
      if (!cpu_req || pc) begin
        cpu_req = $urandom_range(0, 2) != 0; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = rnd_addr(); cpu_wdata = $urandom;
      end
      if (!ext_req || pe) begin
        ext_req = $urandom_range(0, 2) != 0; ext_we = 1'($urandom_range(0, 1));
        ext_addr = rnd_addr(); ext_wdata = $urandom;
      end
    end
    reset = 0;
    step; look;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
